id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/load_use_detect.sv | 24 ++
 rtl/id_ex_stage.sv | 201 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU opcode encodings and the
// control bundle carried from decode into execute.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 4;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t AluAdd  = 4'h0;
    localparam alu_op_t AluSub  = 4'h1;
    localparam alu_op_t AluAnd  = 4'h2;
    localparam alu_op_t AluOr   = 4'h3;
    localparam alu_op_t AluXor  = 4'h4;
    localparam alu_op_t AluSll  = 4'h5;
    localparam alu_op_t AluSrl  = 4'h6;
    localparam alu_op_t AluSra  = 4'h7;
    localparam alu_op_t AluSlt  = 4'h8;
    localparam alu_op_t AluSltu = 4'h9;
    localparam alu_op_t AluPass = 4'hA;

    typedef struct packed {
        logic    we;
        logic    mem_rd;
        logic    mem_wr;
        alu_op_t alu_op;
    } ex_ctrl_t;

    // Strip the side-effecting control bits; the opcode is left untouched.
    function automatic ex_ctrl_t killCtrl(input ex_ctrl_t c);
        ex_ctrl_t r;
        r        = c;
        r.we     = 1'b0;
        r.mem_rd = 1'b0;
        r.mem_wr = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the instruction in EX and the one in ID.
// Purely combinational; all register ids participate (no hardwired zero).
module load_use_detect #(
    parameter int unsigned REG_AW = 4
) (
    input  logic              exValid,
    input  logic              exMemRd,
    input  logic              exWe,
    input  logic              idValid,
    input  logic [REG_AW-1:0] exDst,
    input  logic [REG_AW-1:0] idSrc1,
    input  logic [REG_AW-1:0] idSrc2,
    output logic              loadUse
);

    logic srcMatch;

    // A load in EX whose destination is read by a real instruction in ID.
    always_comb begin
        srcMatch = (exDst == idSrc1) | (exDst == idSrc2);
        loadUse  = exValid & exMemRd & exWe & idValid & srcMatch;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// downstream hold. Optional performance counters are built when the macro
// ID_EX_PERF_EN is defined; otherwise stall_cnt/bubble_cnt read as zero.
module id_ex_stage #(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned REG_AW = cpu_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic [REG_AW-1:0] id_dst,
    input  logic [DATA_W-1:0] id_rd_data1,
    input  logic [DATA_W-1:0] id_rd_data2,
    input  logic [3:0]        id_alu_op,
    input  logic              id_we,
    input  logic              id_mem_rd,
    input  logic              id_mem_wr,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              id_stall,
    output logic              ex_valid,
    output logic              ex_we,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr,
    output logic [3:0]        ex_alu_op,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_src1,
    output logic [REG_AW-1:0] ex_src2,
    output logic [REG_AW-1:0] ex_dst,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       bubble_cnt
);

    import cpu_pkg::*;

    logic              loadUse;
    ex_ctrl_t          idCtrl;

    logic              validQ, validD;
    ex_ctrl_t          ctrlQ, ctrlD;
    logic [DATA_W-1:0] pcQ, pcD;
    logic [DATA_W-1:0] op1Q, op1D;
    logic [DATA_W-1:0] op2Q, op2D;
    logic [DATA_W-1:0] immQ, immD;
    logic [REG_AW-1:0] src1Q, src1D;
    logic [REG_AW-1:0] src2Q, src2D;
    logic [REG_AW-1:0] dstQ, dstD;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .exValid (validQ),
        .exMemRd (ctrlQ.mem_rd),
        .exWe    (ctrlQ.we),
        .idValid (id_valid),
        .exDst   (dstQ),
        .idSrc1  (id_src1),
        .idSrc2  (id_src2),
        .loadUse (loadUse)
    );

    // Flush overrides everything, so a killed slot never asks upstream to wait.
    always_comb begin
        id_stall = (ex_hold | loadUse) & ~flush;
    end

    // Bundle the decode control bits the way they are stored in EX.
    always_comb begin
        idCtrl.we     = id_we;
        idCtrl.mem_rd = id_mem_rd;
        idCtrl.mem_wr = id_mem_wr;
        idCtrl.alu_op = alu_op_t'(id_alu_op);
    end

    // Next-state selection: flush > ex_hold > load-use bubble > advance.
    always_comb begin
        validD = validQ;
        ctrlD  = ctrlQ;
        pcD    = pcQ;
        op1D   = op1Q;
        op2D   = op2Q;
        immD   = immQ;
        src1D  = src1Q;
        src2D  = src2Q;
        dstD   = dstQ;

        if (flush) begin
            // Data still tracks ID so the killed slot costs no extra muxing.
            validD = 1'b0;
            ctrlD  = killCtrl(idCtrl);
            pcD    = id_pc;
            op1D   = id_rd_data1;
            op2D   = id_rd_data2;
            immD   = id_imm;
            src1D  = id_src1;
            src2D  = id_src2;
            dstD   = id_dst;
        end else if (ex_hold) begin
            // Everything already holds via the defaults.
            validD = validQ;
        end else if (loadUse) begin
            // Bubble: the load moves on, the consumer re-presents next cycle.
            validD = 1'b0;
            ctrlD  = killCtrl(ctrlQ);
        end else begin
            validD = id_valid;
            ctrlD  = id_valid ? idCtrl : killCtrl(idCtrl);
            pcD    = id_pc;
            op1D   = id_rd_data1;
            op2D   = id_rd_data2;
            immD   = id_imm;
            src1D  = id_src1;
            src2D  = id_src2;
            dstD   = id_dst;
        end
    end

    // Pipeline register; asynchronous clear so EX is empty the moment rst drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validQ <= 1'b0;
            ctrlQ  <= '0;
            pcQ    <= '0;
            op1Q   <= '0;
            op2Q   <= '0;
            immQ   <= '0;
            src1Q  <= '0;
            src2Q  <= '0;
            dstQ   <= '0;
        end else begin
            validQ <= validD;
            ctrlQ  <= ctrlD;
            pcQ    <= pcD;
            op1Q   <= op1D;
            op2Q   <= op2D;
            immQ   <= immD;
            src1Q  <= src1D;
            src2Q  <= src2D;
            dstQ   <= dstD;
        end
    end

    // Drive the EX-side outputs straight from the register.
    always_comb begin
        ex_valid  = validQ;
        ex_we     = ctrlQ.we;
        ex_mem_rd = ctrlQ.mem_rd;
        ex_mem_wr = ctrlQ.mem_wr;
        ex_alu_op = ctrlQ.alu_op;
        ex_pc     = pcQ;
        ex_op1    = op1Q;
        ex_op2    = op2Q;
        ex_imm    = immQ;
        ex_src1   = src1Q;
        ex_src2   = src2Q;
        ex_dst    = dstQ;
    end

`ifdef ID_EX_PERF_EN
    logic [15:0] stallCntQ;
    logic [15:0] bubbleCntQ;
    logic        bubbleIns;

    always_comb begin
        bubbleIns = loadUse & ~flush & ~ex_hold;
    end

    // Saturating event counters; they stick at all-ones rather than wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCntQ  <= '0;
            bubbleCntQ <= '0;
        end else begin
            if (id_stall && (stallCntQ != 16'hFFFF)) begin
                stallCntQ <= stallCntQ + 16'd1;
            end
            if (bubbleIns && (bubbleCntQ != 16'hFFFF)) begin
                bubbleCntQ <= bubbleCntQ + 16'd1;
            end
        end
    end

    always_comb begin
        stall_cnt  = stallCntQ;
        bubble_cnt = bubbleCntQ;
    end
`else
    always_comb begin
        stall_cnt  = 16'd0;
        bubble_cnt = 16'd0;
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage. A reference model predicts the EX
// state for each driven cycle; predictions go through a scoreboard queue and
// are compared after the clock edge. Counter checks follow ID_EX_PERF_EN.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic        mrd;
        logic        mwr;
        logic [3:0]  op;
        logic [15:0] pc;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] imm;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  d;
        logic [15:0] sc;
        logic [15:0] bc;
    } exState_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [15:0] id_pc = '0, id_imm = '0, id_rd_data1 = '0, id_rd_data2 = '0;
    logic [3:0]  id_src1 = '0, id_src2 = '0, id_dst = '0, id_alu_op = '0;
    logic        id_we = 1'b0, id_mem_rd = 1'b0, id_mem_wr = 1'b0;
    logic        flush = 1'b0, ex_hold = 1'b0;
    logic        id_stall, ex_valid, ex_we, ex_mem_rd, ex_mem_wr;
    logic [3:0]  ex_alu_op, ex_src1, ex_src2, ex_dst;
    logic [15:0] ex_pc, ex_op1, ex_op2, ex_imm, stall_cnt, bubble_cnt;

    int       errors = 0;
    int       checks = 0;
    exState_t model = '0;
    exState_t sbQueue[$];

    always #5 clk = ~clk;

    id_ex_stage #(
        .DATA_W (16),
        .REG_AW (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_imm      (id_imm),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_dst      (id_dst),
        .id_rd_data1 (id_rd_data1),
        .id_rd_data2 (id_rd_data2),
        .id_alu_op   (id_alu_op),
        .id_we       (id_we),
        .id_mem_rd   (id_mem_rd),
        .id_mem_wr   (id_mem_wr),
        .flush       (flush),
        .ex_hold     (ex_hold),
        .id_stall    (id_stall),
        .ex_valid    (ex_valid),
        .ex_we       (ex_we),
        .ex_mem_rd   (ex_mem_rd),
        .ex_mem_wr   (ex_mem_wr),
        .ex_alu_op   (ex_alu_op),
        .ex_pc       (ex_pc),
        .ex_op1      (ex_op1),
        .ex_op2      (ex_op2),
        .ex_imm      (ex_imm),
        .ex_src1     (ex_src1),
        .ex_src2     (ex_src2),
        .ex_dst      (ex_dst),
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
    );

    task automatic checkVal(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exState_t observed();
        exState_t o;
        o.valid = ex_valid;
        o.we    = ex_we;
        o.mrd   = ex_mem_rd;
        o.mwr   = ex_mem_wr;
        o.op    = ex_alu_op;
        o.pc    = ex_pc;
        o.op1   = ex_op1;
        o.op2   = ex_op2;
        o.imm   = ex_imm;
        o.s1    = ex_src1;
        o.s2    = ex_src2;
        o.d     = ex_dst;
        o.sc    = stall_cnt;
        o.bc    = bubble_cnt;
        return o;
    endfunction

    function automatic logic modelLoadUse();
        return model.valid && model.mrd && model.we && id_valid &&
               ((model.d == id_src1) || (model.d == id_src2));
    endfunction

    function automatic logic modelStall();
        return (ex_hold || modelLoadUse()) && !flush;
    endfunction

    // Predict the EX state after the coming edge from the current inputs.
    function automatic exState_t predict();
        exState_t n;
        logic     lu;
        n  = model;
        lu = modelLoadUse();
        if (flush || (!ex_hold && !lu)) begin
            n.valid = flush ? 1'b0 : id_valid;
            n.we    = flush ? 1'b0 : (id_we & id_valid);
            n.mrd   = flush ? 1'b0 : (id_mem_rd & id_valid);
            n.mwr   = flush ? 1'b0 : (id_mem_wr & id_valid);
            n.op    = id_alu_op;
            n.pc    = id_pc;
            n.op1   = id_rd_data1;
            n.op2   = id_rd_data2;
            n.imm   = id_imm;
            n.s1    = id_src1;
            n.s2    = id_src2;
            n.d     = id_dst;
        end else if (!ex_hold) begin
            n.valid = 1'b0;
            n.we    = 1'b0;
            n.mrd   = 1'b0;
            n.mwr   = 1'b0;
        end
`ifdef ID_EX_PERF_EN
        if (modelStall() && model.sc != 16'hFFFF) n.sc = model.sc + 16'd1;
        if (!flush && !ex_hold && lu && model.bc != 16'hFFFF) n.bc = model.bc + 16'd1;
`else
        n.sc = 16'd0;
        n.bc = 16'd0;
`endif
        return n;
    endfunction

    // One cycle: check id_stall, push the prediction, clock, pop and compare.
    task automatic step(input string tag);
        exState_t exp;
        #1;
        checkVal({tag, "_stall"}, 128'(id_stall), 128'(modelStall()));
        sbQueue.push_back(predict());
        @(posedge clk);
        #1;
        checkVal({tag, "_sb_depth"}, 128'(sbQueue.size()), 128'd1);
        if (sbQueue.size() != 0) begin
            exp   = sbQueue.pop_front();
            model = exp;
            checkVal({tag, "_ex"}, 128'(observed()), 128'(exp));
        end
    endtask

    task automatic idleInputs();
        id_valid  = 1'b0; id_we = 1'b0; id_mem_rd = 1'b0; id_mem_wr = 1'b0;
        id_pc     = '0;   id_imm = '0;  id_rd_data1 = '0; id_rd_data2 = '0;
        id_src1   = '0;   id_src2 = '0; id_dst = '0;      id_alu_op = '0;
        flush     = 1'b0; ex_hold = 1'b0;
    endtask

    task automatic randInputs();
        id_valid    = ($urandom_range(0, 9) < 8);
        id_we       = 1'($urandom);
        id_mem_rd   = ($urandom_range(0, 2) == 0);
        id_mem_wr   = ($urandom_range(0, 4) == 0);
        id_pc       = 16'($urandom);
        id_imm      = 16'($urandom);
        id_rd_data1 = 16'($urandom);
        id_rd_data2 = 16'($urandom);
        id_src1     = 4'($urandom_range(0, 3));
        id_src2     = 4'($urandom_range(0, 3));
        id_dst      = 4'($urandom_range(0, 3));
        id_alu_op   = 4'($urandom);
        flush       = ($urandom_range(0, 9) == 0);
        ex_hold     = ($urandom_range(0, 4) == 0);
    endtask

    initial begin
        logic [15:0] scBefore;
        exState_t    held;

        // Reset: EX and counters clear without a clock edge.
        #2 rst = 1'b0;
        #1;
        checkVal("reset_state", 128'(observed()), 128'(exState_t'('0)));
        ex_hold = 1'b1;
        #1 checkVal("reset_stall_hold", 128'(id_stall), 128'd1);
        flush = 1'b1;
        #1 checkVal("reset_stall_flush", 128'(id_stall), 128'd0);
        idleInputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Plain advance with one-cycle latency.
        id_valid = 1'b1; id_pc = 16'h0040; id_rd_data1 = 16'h1234; id_dst = 4'd3;
        id_we = 1'b1; id_alu_op = 4'h0; id_src1 = 4'd1; id_src2 = 4'd2;
        step("advance");
        checkVal("advance_valid", 128'(ex_valid), 128'd1);
        checkVal("advance_pc", 128'(ex_pc), 128'h0040);
        checkVal("advance_op1", 128'(ex_op1), 128'h1234);
        checkVal("advance_dst", 128'(ex_dst), 128'd3);

        // Load to R5, then a consumer reading R5 as src2.
        idleInputs();
        id_valid = 1'b1; id_we = 1'b1; id_mem_rd = 1'b1; id_dst = 4'd5; id_pc = 16'h0044;
        step("load");
        idleInputs();
        id_valid = 1'b1; id_we = 1'b1; id_src1 = 4'd1; id_src2 = 4'd5; id_dst = 4'd6;
        id_pc = 16'h0048; id_rd_data2 = 16'hBEEF;
        #1 checkVal("lu_stall_set", 128'(id_stall), 128'd1);
        step("lu_bubble");
        checkVal("lu_bubble_valid", 128'(ex_valid), 128'd0);
        #1 checkVal("lu_stall_clear", 128'(id_stall), 128'd0);
        step("lu_consume");
        checkVal("lu_consume_valid", 128'(ex_valid), 128'd1);
        checkVal("lu_consume_pc", 128'(ex_pc), 128'h0048);
        checkVal("lu_consume_src2", 128'(ex_src2), 128'd5);
        checkVal("lu_bubble_cnt", 128'(bubble_cnt),
`ifdef ID_EX_PERF_EN
                 128'd1);
`else
                 128'd0);
`endif

        // Flush wins over hold.
        flush = 1'b1; ex_hold = 1'b1;
        #1 checkVal("flush_hold_stall", 128'(id_stall), 128'd0);
        step("flush_hold");
        checkVal("flush_hold_valid", 128'(ex_valid), 128'd0);

        // Three held cycles with changing decode inputs.
        idleInputs();
        id_valid = 1'b1; id_pc = 16'h0100; id_dst = 4'd9;
        step("pre_hold");
        held     = observed();
        scBefore = stall_cnt;
        for (int i = 0; i < 3; i++) begin
            randInputs();
            flush = 1'b0; ex_hold = 1'b1;
            #1 checkVal("hold_stall", 128'(id_stall), 128'd1);
            step("hold");
            checkVal("hold_ex_pc", 128'(ex_pc), 128'(held.pc));
        end
        checkVal("hold_stall_cnt", 128'(stall_cnt - scBefore),
`ifdef ID_EX_PERF_EN
                 128'd3);
`else
                 128'd0);
`endif

        // Random mix of advance, bubble, flush and hold.
        for (int i = 0; i < 300; i++) begin
            randInputs();
            step("random");
        end

        // Asynchronous reset while EX holds a valid instruction.
        idleInputs();
        flush = 1'b1;
        step("pre_rst_flush");
        idleInputs();
        id_valid = 1'b1; id_we = 1'b1; id_pc = 16'h0200;
        step("pre_rst_adv");
        checkVal("pre_rst_valid", 128'(ex_valid), 128'd1);
        #2 rst = 1'b0;
        #1;
        checkVal("midrun_reset_state", 128'(observed()), 128'(exState_t'('0)));
        model = '0;
        #1 rst = 1'b1;
        randInputs();
        flush = 1'b0; ex_hold = 1'b0;
        step("post_rst_adv");

`ifdef ID_EX_PERF_EN
        // Drive stall_cnt well past its ceiling.
        idleInputs();
        ex_hold = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
            if (model.sc != 16'hFFFF) model.sc = model.sc + 16'd1;
        end
        #1 checkVal("sat_stall_cnt", 128'(stall_cnt), 128'hFFFF);
        step("sat_hold1");
        step("sat_hold2");
        checkVal("sat_stays", 128'(stall_cnt), 128'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
